// File: rtl/sync_fifo_pkg.sv
// Shared defaults and helpers for the threshold FIFO.
// Optional first-word fall-through is selected by defining SYNC_FIFO_FWFT_EN.
package sync_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 4;
  localparam int DEFAULT_AFULL_TH   = 14;
  localparam int DEFAULT_AEMPTY_TH  = 2;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  typedef struct packed {
    logic wfull;
    logic rempty;
    logic walmost_full;
    logic ralmost_empty;
  } level_flags_t;

endpackage

// File: rtl/sync_fifo_thresh_if.sv
// Handshake, data and status bundle between a FIFO user (master) and the FIFO (slave).
interface sync_fifo_thresh_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

  logic                  winc;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rinc;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  wfull;
  logic                  rempty;
  logic                  walmost_full;
  logic                  ralmost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output winc, wdata, rinc, clr_err,
    input  rdata, wfull, rempty, walmost_full, ralmost_empty, count, overflow, underflow
  );

  modport slave (
    input  winc, wdata, rinc, clr_err,
    output rdata, wfull, rempty, walmost_full, ralmost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one combinational read port.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset; stale words are unreachable because the pointers reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_thresh.sv
// Synchronous FIFO with fill count, almost-full/almost-empty thresholds and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through; otherwise rdata is registered per pop.
module sync_fifo_thresh
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int AFULL_TH   = DEFAULT_AFULL_TH,
  parameter int AEMPTY_TH  = DEFAULT_AEMPTY_TH
) (
  input  logic               clk,
  input  logic               rst_n,
  sync_fifo_thresh_if.slave  bus
);

  localparam int PW = ptr_width(ADDR_WIDTH);

  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [PW-1:0]         count;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_en, rd_en;
  logic [DATA_WIDTH-1:0] mem_rdata;
  level_flags_t          flags;

  // Level status is derived purely from the registered pointers, so it
  // follows the pointer state one edge after an accepted operation.
  always_comb begin
    count               = wptr_q - rptr_q;
    flags.rempty        = (wptr_q == rptr_q);
    flags.wfull         = (wptr_q[PW-1] != rptr_q[PW-1]) &&
                          (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);
    flags.walmost_full  = (count >= PW'(AFULL_TH));
    flags.ralmost_empty = (count <= PW'(AEMPTY_TH));
  end

  assign wr_en = bus.winc && !flags.wfull;
  assign rd_en = bus.rinc && !flags.rempty;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (wr_en) wptr_d = wptr_q + PW'(1);
    if (rd_en) rptr_d = rptr_q + PW'(1);
    if (bus.winc && flags.wfull) begin
      overflow_d = 1'b1;
    end else if (bus.clr_err) begin
      overflow_d = 1'b0;
    end
    if (bus.rinc && flags.rempty) begin
      underflow_d = 1'b1;
    end else if (bus.clr_err) begin
      underflow_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wptr_q[ADDR_WIDTH-1:0]),
    .wdata (bus.wdata),
    .raddr (rptr_q[ADDR_WIDTH-1:0]),
    .rdata (mem_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented combinationally; forced to zero while empty.
  assign bus.rdata = flags.rempty ? '0 : mem_rdata;
`else
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) rdata_d = mem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign bus.rdata = rdata_q;
`endif

  assign bus.count         = count;
  assign bus.wfull         = flags.wfull;
  assign bus.rempty        = flags.rempty;
  assign bus.walmost_full  = flags.walmost_full;
  assign bus.ralmost_empty = flags.ralmost_empty;
  assign bus.overflow      = overflow_q;
  assign bus.underflow     = underflow_q;

endmodule
